serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial inverse of the lab adder. Given a sum `value` and one addend `b`, it recovers the other addend `a = value - b`. The subtraction runs LSB-first, one bit per clock, under a start/ready/valid handshake. The block sits downstream of the adder so that adder results can be checked in hardware: feeding `value` and `b` back in must return the original `a`.

## Interface
Parameters:
- `WIDTH`, default 4: addend width. `value` is `WIDTH+1` bits; `b` and `a` are `WIDTH` bits.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only while `ready`=1.
- `value` input `WIDTH+1`: minuend (adder sum); latched when the start is accepted.
- `b` input `WIDTH`: subtrahend; latched when the start is accepted.
- `ready` output 1: high in IDLE; a start can be accepted.
- `busy` output 1: high in RUN.
- `valid` output 1: one-cycle pulse; `a` and `err` are final.
- `a` output `WIDTH`: result, `(value - b) mod 2^WIDTH`; held until the next accepted start completes.
- `err` output 1: range error, see Configuration; held with `a`.

## Operation
- State machine:
  - IDLE: `ready`=1. `start`=1 latches `value` into a shift register and `{1'b0,b}` into a second shift register. It clears borrow and bit counter, and moves to RUN.
  - RUN: `busy`=1. Each edge computes one bit:
    - `d = v0 ^ b0 ^ borrow`
    - `borrow' = (~v0 & b0) | (~(v0 ^ b0) & borrow)`
    - `d` shifts into the result register MSB-side; both operand registers shift right.
    - After `WIDTH+1` bits the state moves to DONE.
  - DONE: `valid`=1 for exactly one cycle, then unconditionally back to IDLE.
- Full result is `r = (value - {0,b}) mod 2^(WIDTH+1)`.
  - `a = r[WIDTH-1:0]`.
  - The final borrow and `r[WIDTH]` feed `err`.
- `start` while not in IDLE (RUN or DONE) is ignored; it is neither queued nor allowed to disturb the operation in progress.
- `value`/`b` changes after acceptance have no effect.
- `a`/`err` update only on the RUN→DONE transition. During RUN they keep the previous result; internal shifting is not visible on them.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `valid`=0, `a`=0, `err`=0; internal registers cleared.
- Start accepted at edge k:
  - `busy`=1 from k through k+`WIDTH`.
  - `valid`=1 in the cycle after edge k+`WIDTH`+1.
  - `ready`=1 again after edge k+`WIDTH`+2.
  - For WIDTH=4: 5 RUN cycles; `valid` 5 cycles after acceptance; throughput one operation per `WIDTH`+3 cycles.
- `ready`=0 in DONE, so back-to-back starts need `start` held through DONE into IDLE.
- Reset asserted in any state (including mid-RUN or the DONE cycle) returns everything to the reset values on that edge. A partial result is discarded and no `valid` is produced.
- `rst` and `start` both high on the same edge: reset wins.

## Configuration
- Macro `SERIAL_SUB_RANGE_CHECK_EN` enables the range check.
- Defined:
  - `err = final_borrow | r[WIDTH]`.
  - `err` is high when `value < b`, or when the true difference does not fit in `WIDTH` bits.
  - `err` is registered and updated with `a`.
- Undefined:
  - `err` is tied to 0 and no check logic is built.
  - `a` and all timing are unchanged.

## Test plan
WIDTH=4. Each operation is: start, wait for `valid`, check `a`/`err`.
- Reset, then `value`=0x03, `b`=0x2 → `a`=0x1, `err`=0; `valid` exactly 5 cycles after acceptance, 1 cycle wide.
- Adder round trip, sequence (0x07,0x3), (0x0C,0x3), (0x15,0xB) → `a` = 0x4, 0x9, 0xA; `err`=0 for all three.
- Underflow (0x02,0x5) → `a`=0xD; `err`=1 with the macro, 0 without. Out of range (0x1F,0x0) → `a`=0xF; `err`=1 with the macro, 0 without.
- `start` pulsed with (0x03,0x1) during RUN of (0x0C,0x3) → one `valid` only, `a`=0x9; `ready` stays low until IDLE.
- `rst` asserted 2 cycles into RUN → `ready`=1, `busy`=0, `a`=0, `err`=0 on that edge; no `valid`. A following (0x07,0x3) gives `a`=0x4.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: recovers a = value - b for checking adder results.
// Optional range check on err is built only when SERIAL_SUB_RANGE_CHECK_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH:0]   value,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   v_q, v_d;
    logic [WIDTH:0]   b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             diff_bit;
    logic             borrow_next;
    logic             last_bit;

    assign diff_bit    = v_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_next = (~v_q[0] & b_q[0]) | (~(v_q[0] ^ b_q[0]) & borrow_q);
    assign last_bit    = (cnt_q == CW'(WIDTH));

`ifdef SERIAL_SUB_RANGE_CHECK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        b_d      = b_q;
        res_d    = res_q;
        a_d      = a_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        ready    = 1'b0;
        busy     = 1'b0;
        valid    = 1'b0;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    v_d      = value;
                    b_d      = {1'b0, b};
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                borrow_d = borrow_next;
                v_d      = v_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    // The final bit is r[WIDTH]; only the low WIDTH bits form a.
                    a_d     = res_q;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
                    err_d   = borrow_next | diff_bit;
`endif
                    state_d = S_DONE;
                end else begin
                    res_d = {diff_bit, res_q[WIDTH-1:1]};
                end
            end
            S_DONE: begin
                valid   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            v_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            a_q      <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            b_q      <= b_d;
            res_q    <= res_d;
            a_q      <= a_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERIAL_SUB_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign a = a_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: timeline model checked every cycle plus literal results.
module tb_serial_subtractor;

    localparam int W = 4;
`ifdef SERIAL_SUB_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W:0]   value;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] a;
    logic         err;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .valid (valid),
        .a     (a),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted start at edge k defines every output for the next W+2 edges.
    int           edge_n     = 0;
    int           acc_k      = 0;
    bit           pend       = 1'b0;
    bit           model_live = 1'b0;
    int           lat_v      = 0;
    int           lat_b      = 0;
    logic [W-1:0] exp_a      = '0;
    logic         exp_err    = 1'b0;

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) begin
            pend       <= 1'b0;
            exp_a      <= '0;
            exp_err    <= 1'b0;
            model_live <= 1'b1;
        end else if (!pend) begin
            if (start) begin
                pend  <= 1'b1;
                acc_k <= edge_n + 1;
                lat_v <= int'(value);
                lat_b <= int'(b);
            end
        end else if (edge_n + 1 == acc_k + W + 1) begin
            exp_a   <= W'(lat_v - lat_b);
            exp_err <= RC && ((lat_v < lat_b) || (lat_v - lat_b > (1 << W) - 1));
        end else if (edge_n + 1 == acc_k + W + 2) begin
            pend <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("ready", 32'(ready), 32'(!pend));
            chk("busy",  32'(busy),  32'(pend && (edge_n - acc_k) <= W));
            chk("valid", 32'(valid), 32'(pend && (edge_n == acc_k + W + 1)));
            chk("a",     32'(a),     32'(exp_a));
            chk("err",   32'(err),   32'(exp_err));
        end
    end

    task automatic do_op(input logic [W:0] v, input logic [W-1:0] bb,
                         input logic [W-1:0] ea, input logic ee, input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        value = v; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; value = ~v; b = ~bb;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                n = i;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(n), 32'd5);
        chk({tag, "_a"}, 32'(a), 32'(ea));
        chk({tag, "_err"}, 32'(err), 32'(ee));
        $display("op %s value=%0h b=%0h -> a=%0h err=%0b latency=%0d", tag, v, bb, a, err, n);
        @(posedge clk); #1;
        chk({tag, "_valid_width"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int vcount;
        logic [W-1:0] va;
        rst = 1'b1; start = 1'b0; value = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_a",     32'(a),     32'd0);
        chk("rst_err",   32'(err),   32'd0);
        rst = 1'b0;

        do_op(5'h03, 4'h2, 4'h1, 1'b0, "basic");
        do_op(5'h07, 4'h3, 4'h4, 1'b0, "rt1");
        do_op(5'h0C, 4'h3, 4'h9, 1'b0, "rt2");
        do_op(5'h15, 4'hB, 4'hA, 1'b0, "rt3");
        do_op(5'h02, 4'h5, 4'hD, RC, "underflow");
        do_op(5'h1F, 4'h0, 4'hF, RC, "overrange");

        // Start pulsed during RUN must be ignored.
        @(posedge clk); #1;
        value = 5'h0C; b = 4'h3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        value = 5'h03; b = 4'h1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore_ready", 32'(ready), 32'd0);
        vcount = 0; va = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                vcount++;
                va = a;
            end
        end
        chk("ignore_vcount", 32'(vcount), 32'd1);
        chk("ignore_a", 32'(va), 32'h9);
        $display("op ignore value=0c b=3 (start pulsed in RUN) -> valids=%0d a=%0h", vcount, va);

        // Reset two cycles into RUN, with start also high: reset wins.
        @(posedge clk); #1;
        value = 5'h15; b = 4'hB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy",  32'(busy),  32'd0);
        chk("midrst_a",     32'(a),     32'd0);
        chk("midrst_err",   32'(err),   32'd0);
        rst = 1'b0; start = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid) vcount++;
        end
        chk("midrst_novalid", 32'(vcount), 32'd0);
        $display("op midrun_reset -> ready=%0b busy=%0b a=%0h valids=%0d", ready, busy, a, vcount);
        do_op(5'h07, 4'h3, 4'h4, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
